cordic_angle_frontend: RTL and testbench

Upstream stage of the `cordic` sin/cos core. It accepts full-circle angles in [-π, π] over a valid/ready handshake and folds each one into the core's [-π/2, π/2] range. It then drives the core's start/angle_in/done interface and applies the quadrant sign fix to cos/sin. It presents results on a valid/ready output, so the core can be used anywhere on the circle with one request in flight.

---
 rtl/cordic_angle_frontend.sv | 200 ++++++++++++++++++++
 tb/tb_cordic_angle_frontend.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_angle_frontend.sv
// Angle front end for the `cordic` sin/cos core: clamps and folds full-circle angles, sequences the core, fixes quadrant signs.
// Optional watchdog in WAIT is enabled with macro CORDIC_FE_TIMEOUT_EN.
module cordic_angle_frontend #(
  parameter int WL    = 16,
  parameter int FL    = 14,
  parameter int PI_IN = 25736
`ifdef CORDIC_FE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_angle,
  output logic          cordic_start,
  output logic [WL-1:0] cordic_angle,
  input  logic          cordic_done,
  input  logic [WL-1:0] cordic_cos,
  input  logic [WL-1:0] cordic_sin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_cos,
  output logic [WL-1:0] out_sin,
  output logic          out_clamped,
  output logic          out_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic signed [WL:0] PI_X      = (WL+1)'(PI_IN);
  localparam logic signed [WL:0] NEG_PI_X  = -PI_X;
  localparam logic signed [WL:0] HALF_X    = (WL+1)'(PI_IN / 2);
  localparam logic signed [WL:0] NEG_HALF_X = -HALF_X;
  localparam int RESCALE = FL - (FL - 1);

`ifdef CORDIC_FE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  state_t          state_q, state_d;
  logic [WL-1:0]   angle_q, angle_d;
  logic            flip_q, flip_d;
  logic            clamp_q, clamp_d;
  logic [WL-1:0]   cos_q, cos_d;
  logic [WL-1:0]   sin_q, sin_d;
  logic            oclamp_q, oclamp_d;
  logic            err_q, err_d;

  logic signed [WL:0] a_ext_s, a_clamp_s, r_s, r_scaled_s;
  logic               clamp_s, flip_s;

  // Two's-complement negation that maps the most negative code to the most positive one.
  function automatic logic [WL-1:0] neg_sat(input logic [WL-1:0] x, input logic en);
    if (!en) begin
      return x;
    end else if (x == {1'b1, {(WL-1){1'b0}}}) begin
      return {1'b0, {(WL-1){1'b1}}};
    end else begin
      return -x;
    end
  endfunction

  always_comb begin
    a_ext_s   = $signed({in_angle[WL-1], in_angle});
    clamp_s   = 1'b0;
    a_clamp_s = a_ext_s;
    if (a_ext_s > PI_X) begin
      a_clamp_s = PI_X;
      clamp_s   = 1'b1;
    end else if (a_ext_s < NEG_PI_X) begin
      a_clamp_s = NEG_PI_X;
      clamp_s   = 1'b1;
    end else begin
      a_clamp_s = a_ext_s;
    end
    // Exactly +/- pi/2 stays unflipped; the core covers the closed range.
    flip_s = 1'b0;
    r_s    = a_clamp_s;
    if (a_clamp_s > HALF_X) begin
      r_s    = a_clamp_s - PI_X;
      flip_s = 1'b1;
    end else if (a_clamp_s < NEG_HALF_X) begin
      r_s    = a_clamp_s + PI_X;
      flip_s = 1'b1;
    end else begin
      r_s = a_clamp_s;
    end
    r_scaled_s = r_s <<< RESCALE;
  end

  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    flip_d   = flip_q;
    clamp_d  = clamp_q;
    cos_d    = cos_q;
    sin_d    = sin_q;
    oclamp_d = oclamp_q;
    err_d    = err_q;
`ifdef CORDIC_FE_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_START;
          angle_d = r_scaled_s[WL-1:0];
          flip_d  = flip_s;
          clamp_d = clamp_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef CORDIC_FE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (cordic_done) begin
          cos_d    = neg_sat(cordic_cos, flip_q);
          sin_d    = neg_sat(cordic_sin, flip_q);
          oclamp_d = clamp_q;
          err_d    = 1'b0;
          state_d  = S_OUT;
        end
`ifdef CORDIC_FE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cos_d    = '0;
          sin_d    = '0;
          oclamp_d = clamp_q;
          err_d    = 1'b1;
          state_d  = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      angle_q  <= '0;
      flip_q   <= 1'b0;
      clamp_q  <= 1'b0;
      cos_q    <= '0;
      sin_q    <= '0;
      oclamp_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef CORDIC_FE_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      flip_q   <= flip_d;
      clamp_q  <= clamp_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
      oclamp_q <= oclamp_d;
      err_q    <= err_d;
`ifdef CORDIC_FE_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign cordic_start = (state_q == S_START);
  assign out_valid    = (state_q == S_OUT);
  assign cordic_angle = angle_q;
  assign out_cos      = cos_q;
  assign out_sin      = sin_q;
  assign out_clamped  = oclamp_q;
  assign out_err      = err_q;

endmodule

// File: tb/tb_cordic_angle_frontend.sv
// Self-checking bench for cordic_angle_frontend: directed test-plan cases plus randomized angles against a reference model.
module tb_cordic_angle_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_angle;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic        cordic_done;
  logic [15:0] cordic_cos;
  logic [15:0] cordic_sin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cos;
  logic [15:0] out_sin;
  logic        out_clamped;
  logic        out_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cordic_angle_frontend dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_done(cordic_done), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cos(out_cos), .out_sin(out_sin),
    .out_clamped(out_clamped), .out_err(out_err)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: clamp to [-pi, pi], fold into [-pi/2, pi/2], rescale by 2.
  function automatic void ref_fold(input int a, output int ang, output bit flip, output bit clamp);
    int c;
    c = a;
    clamp = 1'b0;
    if (a > 25736) begin c = 25736; clamp = 1'b1; end
    else if (a < -25736) begin c = -25736; clamp = 1'b1; end
    flip = 1'b0;
    ang  = c;
    if (c > 12868) begin ang = c - 25736; flip = 1'b1; end
    else if (c < -12868) begin ang = c + 25736; flip = 1'b1; end
    ang = ang * 2;
  endfunction

  function automatic int ref_fix(input int v, input bit flip);
    if (!flip) return v;
    if (v == -32768) return 32767;
    return -v;
  endfunction

  task automatic run_txn(input int a, input int c, input int s, input int done_dly,
                         input int rdy_dly, input bit early);
    int e_ang, e_cos, e_sin;
    bit e_flip, e_cl;
    ref_fold(a, e_ang, e_flip, e_cl);
    e_cos = ref_fix(c, e_flip);
    e_sin = ref_fix(s, e_flip);
    check_val("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_angle = a[15:0];
    if (early) begin
      cordic_done = 1'b1;
      cordic_cos  = 16'h1234;
      cordic_sin  = 16'h4321;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_angle = 16'($urandom);
    check_val("start_pulse", cordic_start, 1);
    check_val("cordic_angle", $signed(cordic_angle), e_ang);
    check_val("in_ready_busy", in_ready, 0);
    @(negedge clk);
    cordic_done = 1'b0;
    check_val("start_one_cycle", cordic_start, 0);
    check_val("no_early_valid", out_valid, 0);
    for (int i = 0; i < done_dly; i++) begin
      @(negedge clk);
      check_val("wait_no_valid", out_valid, 0);
    end
    cordic_done = 1'b1;
    cordic_cos  = c[15:0];
    cordic_sin  = s[15:0];
    @(negedge clk);
    cordic_done = 1'b0;
    cordic_cos  = 16'($urandom);
    cordic_sin  = 16'($urandom);
    check_val("out_valid", out_valid, 1);
    check_val("out_cos", $signed(out_cos), e_cos);
    check_val("out_sin", $signed(out_sin), e_sin);
    check_val("out_clamped", out_clamped, int'(e_cl));
    check_val("out_err", out_err, 0);
    check_val("in_ready_out", in_ready, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_cos", $signed(out_cos), e_cos);
      check_val("hold_sin", $signed(out_sin), e_sin);
      check_val("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("valid_drop", out_valid, 0);
    check_val("in_ready_after", in_ready, 1);
  endtask

  initial begin
    int a, c, s;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_angle    = 16'd0;
    cordic_done = 1'b0;
    cordic_cos  = 16'd0;
    cordic_sin  = 16'd0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_angle", cordic_angle, 0);
    check_val("rst_start", cordic_start, 0);
    check_val("rst_cos", out_cos, 0);
    check_val("rst_err", out_err, 0);

    run_txn(0, 16384, 0, 2, 0, 1'b0);
    run_txn(19302, 11585, -11585, 1, 0, 1'b0);
    run_txn(12868, 0, 16384, 0, 0, 1'b0);
    run_txn(-12868, 0, -16384, 3, 1, 1'b0);
    run_txn(-25736, 16384, 0, 1, 0, 1'b0);
    run_txn(20000, -32768, -32768, 0, 0, 1'b0);
    run_txn(-32768, 100, -200, 2, 0, 1'b0);
    run_txn(12000, 5000, 6000, 3, 5, 1'b0);
    run_txn(-19302, 7000, 8000, 2, 0, 1'b1);
    run_txn(30000, 16384, 0, 2, 0, 1'b0);

    // Reset while waiting on the core; a late done must not produce a result.
    check_val("pre_rst_ready", in_ready, 1);
    in_valid = 1'b1;
    in_angle = 16'd20000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_ready", in_ready, 1);
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_angle", cordic_angle, 0);
    check_val("mid_rst_cos", out_cos, 0);
    check_val("mid_rst_sin", out_sin, 0);
    check_val("mid_rst_clamped", out_clamped, 0);
    cordic_done = 1'b1;
    cordic_cos  = 16'd100;
    @(negedge clk);
    cordic_done = 1'b0;
    check_val("late_done_valid", out_valid, 0);
    check_val("late_done_ready", in_ready, 1);
    check_val("late_done_cos", out_cos, 0);

`ifdef CORDIC_FE_TIMEOUT_EN
    begin
      int waited;
      in_valid = 1'b1;
      in_angle = 16'd1000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      waited = 0;
      while (!out_valid && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check_val("timeout_cycles", waited, 64);
      check_val("timeout_err", out_err, 1);
      check_val("timeout_cos", out_cos, 0);
      check_val("timeout_sin", out_sin, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("timeout_release", in_ready, 1);
    end
`endif

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(2) == 0) a = int'($signed(16'($urandom)));
      else a = int'($urandom_range(51472)) - 25736;
      c = int'($signed(16'($urandom)));
      s = int'($signed(16'($urandom)));
      if ($urandom_range(7) == 0) c = -32768;
      run_txn(a, c, s, int'($urandom_range(4)), int'($urandom_range(3)),
              1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
